// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, flag indices, class codes and helpers for the FP adder
package fp_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam int W         = 1 + DEF_EXP_W + DEF_MAN_W;
  localparam int BIAS      = (1 << (DEF_EXP_W - 1)) - 1;
  localparam int SUM_W     = DEF_MAN_W + 5;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  typedef enum logic [2:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_QNAN, CLS_SNAN} fp_cls_e;

  // canonical quiet NaN: all-ones exponent, fraction MSB set, positive sign
  function automatic logic [63:0] qnan(int ew, int mw);
    return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
  endfunction

  // denormals land in CLS_ZERO because they are flushed
  function automatic fp_cls_e classify(logic exp_zero, logic exp_ones, logic frac_zero, logic frac_msb);
    if (exp_zero) return CLS_ZERO;
    if (!exp_ones) return CLS_NORM;
    if (frac_zero) return CLS_INF;
    if (frac_msb) return CLS_QNAN;
    return CLS_SNAN;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: leading-zero count of a vector, WIDTH when the vector is all zeros
module fp_lzc #(
  parameter int WIDTH = 27,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CW-1:0]    cnt_o
);

  // scan upward so the highest set bit decides the count
  always_comb begin
    cnt_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (in_i[i]) cnt_o = CW'(WIDTH - 1 - i);
  end

endmodule

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: three-stage IEEE-754 adder/subtractor with RNE rounding and exception flags
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] a_in,
  input  logic [EXP_W+MAN_W:0] b_in,
  input  logic                 op_sub,
  input  logic                 in_stb,
  output logic                 in_ack,
  output logic [EXP_W+MAN_W:0] z_out,
  output logic [3:0]           z_flags,
  output logic                 z_stb,
  input  logic                 z_ack
);

  localparam int WD  = 1 + EXP_W + MAN_W;
  localparam int NW  = MAN_W + 4;
  localparam int SWD = MAN_W + 5;
  localparam int XW  = EXP_W + 2;
  localparam int CW  = $clog2(NW + 1);
  localparam logic [WD-1:0]        QN   = WD'(qnan(EXP_W, MAN_W));
  localparam logic [EXP_W-1:0]     EMAX = '1;
  localparam logic signed [XW-1:0] XMAX = XW'((1 << EXP_W) - 1);

  logic adv;
  logic v1_q, v2_q, v3_q;
  assign adv    = ~v3_q | z_ack;
  assign in_ack = adv;
  assign z_stb  = v3_q;

  // S1: unpack, classify, order by magnitude, align Y
  logic [WD-1:0]    b_e;
  logic             sa, sb, sx, sy;
  logic [EXP_W-1:0] ea, eb, ex, ey, d;
  logic [MAN_W-1:0] fa, fb, fx, fy;
  fp_cls_e          ca, cb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
  logic [NW-1:0]    sig_y, y_al_d;
  logic [2*NW-1:0]  sh;
  logic             sp_d;
  logic [WD-1:0]    sp_val_d;
  logic [3:0]       sp_flg_d;

  assign b_e    = {b_in[WD-1] ^ op_sub, b_in[WD-2:0]};
  assign {sa, ea, fa} = a_in;
  assign {sb, eb, fb} = b_e;
  assign ca     = classify(ea == '0, &ea, fa == '0, fa[MAN_W-1]);
  assign cb     = classify(eb == '0, &eb, fb == '0, fb[MAN_W-1]);
  assign a_nan  = (ca == CLS_QNAN) | (ca == CLS_SNAN);
  assign b_nan  = (cb == CLS_QNAN) | (cb == CLS_SNAN);
  assign a_inf  = ca == CLS_INF;
  assign b_inf  = cb == CLS_INF;
  assign a_zero = ca == CLS_ZERO;
  assign b_zero = cb == CLS_ZERO;
  assign swap   = ~b_zero & (a_zero | (b_e[WD-2:0] > a_in[WD-2:0]));
  assign {sx, ex, fx} = swap ? b_e : a_in;
  assign {sy, ey, fy} = swap ? a_in : b_e;
  assign sig_y  = (ey == '0) ? '0 : {1'b1, fy, 3'b000};
  assign d      = ex - ey;
  assign sh     = {sig_y, {NW{1'b0}}} >> d;
  assign y_al_d = (int'(d) > NW - 1) ? {{(NW-1){1'b0}}, |sig_y}
                                     : {sh[2*NW-1:NW+1], sh[NW] | (|sh[NW-1:0])};

  // special operands resolve here in priority order; cancellation is left to S2
  always_comb begin
    sp_d     = 1'b1;
    sp_val_d = QN;
    sp_flg_d = '0;
    if (a_nan | b_nan) sp_flg_d[FLG_INV] = (ca == CLS_SNAN) | (cb == CLS_SNAN);
    else if (a_inf & b_inf & (sa != sb)) sp_flg_d[FLG_INV] = 1'b1;
    else if (a_inf | b_inf) sp_val_d = {a_inf ? sa : sb, EMAX, {MAN_W{1'b0}}};
    else if (a_zero & b_zero) sp_val_d = {sa & sb, {(WD-1){1'b0}}};
    else if (a_zero | b_zero) sp_val_d = {sx, ex, fx};
    else sp_d = 1'b0;
  end

  logic             s1_sp_q, s1_sign_q, s1_sub_q;
  logic [WD-1:0]    s1_spv_q;
  logic [3:0]       s1_spf_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [NW-1:0]    s1_sx_q, s1_sy_q;

  // S1 register: aligned significands plus any precomputed special result
  always_ff @(posedge clk)
    if (adv) begin
      s1_sp_q   <= sp_d;
      s1_spv_q  <= sp_val_d;
      s1_spf_q  <= sp_flg_d;
      s1_sign_q <= sx;
      s1_sub_q  <= sx ^ sy;
      s1_exp_q  <= ex;
      s1_sx_q   <= {1'b1, fx, 3'b000};
      s1_sy_q   <= y_al_d;
    end

  // S2: add or subtract magnitudes, then normalise
  logic [SWD-1:0]       sum_d;
  logic [CW-1:0]        lz;
  logic [NW-1:0]        nrm_d;
  logic signed [XW-1:0] exp2_d;

  assign sum_d  = s1_sub_q ? {1'b0, s1_sx_q} - {1'b0, s1_sy_q} : {1'b0, s1_sx_q} + {1'b0, s1_sy_q};
  assign nrm_d  = sum_d[SWD-1] ? {sum_d[SWD-1:2], |sum_d[1:0]} : sum_d[NW-1:0] << lz;
  assign exp2_d = sum_d[SWD-1] ? XW'(s1_exp_q) + XW'(1) : XW'(s1_exp_q) - XW'(lz);

  fp_lzc #(.WIDTH(NW)) u_lzc (
    .in_i  (sum_d[NW-1:0]),
    .cnt_o (lz)
  );

  logic                 s2_sp_q, s2_sign_q;
  logic [WD-1:0]        s2_spv_q;
  logic [3:0]           s2_spf_q;
  logic signed [XW-1:0] s2_exp_q;
  logic [NW-1:0]        s2_nrm_q;

  // S2 register: an exact zero difference becomes a +0 special
  always_ff @(posedge clk)
    if (adv) begin
      s2_sp_q   <= s1_sp_q | (sum_d == '0);
      s2_spv_q  <= s1_sp_q ? s1_spv_q : '0;
      s2_spf_q  <= s1_sp_q ? s1_spf_q : '0;
      s2_sign_q <= s1_sign_q;
      s2_exp_q  <= exp2_d;
      s2_nrm_q  <= nrm_d;
    end

  // S3: round to nearest even, range-check the exponent, pack
  logic                 g, r, s, up, inx, ovf, unf;
  logic [MAN_W+1:0]     mr;
  logic [MAN_W-1:0]     frac3;
  logic signed [XW-1:0] exp3;
  logic [WD-1:0]        z_d, z_out_q;
  logic [3:0]           z_flg_d, z_flg_q;

  assign {g, r, s} = s2_nrm_q[2:0];
  assign up    = g & (r | s | s2_nrm_q[3]);
  assign inx   = g | r | s;
  assign mr    = {1'b0, s2_nrm_q[NW-1:3]} + (MAN_W+2)'(up);
  assign exp3  = s2_exp_q + XW'(mr[MAN_W+1]);
  assign frac3 = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
  assign ovf   = exp3 >= XMAX;
  assign unf   = exp3 <= 0;

  // overflow saturates to infinity, underflow flushes to signed zero
  always_comb begin
    z_d = s2_sp_q ? s2_spv_q
        : ovf     ? {s2_sign_q, EMAX, {MAN_W{1'b0}}}
        : unf     ? {s2_sign_q, {(WD-1){1'b0}}}
        :           {s2_sign_q, exp3[EXP_W-1:0], frac3};
    z_flg_d = '0;
    z_flg_d[FLG_OVF] = ovf;
    z_flg_d[FLG_UNF] = unf;
    z_flg_d[FLG_INX] = ovf | unf | inx;
    if (s2_sp_q) z_flg_d = s2_spf_q;
  end

  // stage valids and the output register move together whenever the output is free
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      z_out_q <= '0;
      z_flg_q <= '0;
    end else if (adv) begin
      v1_q    <= in_stb;
      v2_q    <= v1_q;
      v3_q    <= v2_q;
      z_out_q <= z_d;
      z_flg_q <= z_flg_d;
    end

  assign z_out   = z_out_q;
  assign z_flags = z_flg_q;

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed and randomized back-pressure checks of the binary32 pipelined adder
module tb_fp_add_pipe;

  logic        clk;
  logic        rst;
  logic [31:0] a_in, b_in, z_out;
  logic        op_sub, in_stb, in_ack, z_stb, z_ack;
  logic [3:0]  z_flags;

  int n_chk  = 0;
  int n_pass = 0;

  fp_add_pipe dut (
    .clk     (clk),
    .rst     (rst),
    .a_in    (a_in),
    .b_in    (b_in),
    .op_sub  (op_sub),
    .in_stb  (in_stb),
    .in_ack  (in_ack),
    .z_out   (z_out),
    .z_flags (z_flags),
    .z_stb   (z_stb),
    .z_ack   (z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // exact integer sum scaled to the smaller exponent, then one RNE rounding to 24 bits
  function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic   sa, sb, neg, inx;
    int     ea, eb, emin, p, e, sh;
    longint ma, mb, va, vb, t, m, q, rem, half;
    b[31] = b[31] ^ sub;
    sa = a[31];
    sb = b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0))
      return {((ea == 255 && a[22:0] != 0 && !a[22]) || (eb == 255 && b[22:0] != 0 && !b[22])) ? 4'h8 : 4'h0, 32'h7FC00000};
    if (ea == 255 && eb == 255) return (sa != sb) ? {4'h8, 32'h7FC00000} : {4'h0, a};
    if (ea == 255) return {4'h0, a};
    if (eb == 255) return {4'h0, b};
    if (ea == 0 && eb == 0) return {4'h0, sa & sb, 31'h0};
    if (ea == 0) return {4'h0, b};
    if (eb == 0) return {4'h0, a};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    emin = (ea < eb) ? ea : eb;
    va = ma << (ea - emin);
    vb = mb << (eb - emin);
    if (sa) va = -va;
    if (sb) vb = -vb;
    t = va + vb;
    if (t == 0) return 36'h0;
    neg = t < 0;
    m = neg ? -t : t;
    p = 0;
    for (int i = 0; i < 63; i++) if (m[i]) p = i;
    e = emin + p - 23;
    inx = 1'b0;
    if (p > 23) begin
      sh = p - 23;
      q = m >> sh;
      rem = m - (q << sh);
      half = longint'(1) << (sh - 1);
      inx = rem != 0;
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end else q = m << (23 - p);
    if (e >= 255) return {4'h5, neg, 8'hFF, 23'h0};
    if (e <= 0) return {4'h3, neg, 31'h0};
    return {inx ? 4'h1 : 4'h0, neg, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(1)), 8'(115 + $urandom_range(20)), 23'($urandom)};
  endfunction

  // issue one operation at a negedge and time its arrival with z_ack held high
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [35:0] exp);
    int n;
    a_in = a;
    b_in = b;
    op_sub = sub;
    in_stb = 1'b1;
    @(negedge clk);
    in_stb = 1'b0;
    n = 1;
    while (!z_stb && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd3);
    chk(tag, 64'({z_flags, z_out}), 64'(exp));
  endtask

  localparam int ND = 14;
  logic [31:0] da [ND] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000,
                           32'h7F800001, 32'h00000001, 32'h7F7FFFFF, 32'h00800001, 32'h7FC00000,
                           32'h80000000, 32'h3F800000, 32'h7F800000, 32'h40000000};
  logic [31:0] db [ND] = '{32'h3F800000, 32'h3F800000, 32'h33800000, 32'h33800001, 32'hFF800000,
                           32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h00800000, 32'h3F800000,
                           32'h80000000, 32'h7F800000, 32'h7F800000, 32'hBF800000};
  logic        ds [ND] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [35:0] de [ND] = '{36'h0_40000000, 36'h0_00000000, 36'h1_3F800000, 36'h1_3F800001,
                           36'h8_7FC00000, 36'h8_7FC00000, 36'h0_3F800000, 36'h5_7F800000,
                           36'h3_00000000, 36'h0_7FC00000, 36'h0_80000000, 36'h0_FF800000,
                           36'h8_7FC00000, 36'h0_3F800000};

  logic [35:0] expq [$];
  logic [35:0] want;
  logic [36:0] held;
  int          sent, got, cyc;
  logic        acc, stall;

  initial begin
    rst = 1'b0;
    in_stb = 1'b0;
    z_ack = 1'b1;
    op_sub = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stb", 64'(z_stb), 64'd0);
    chk("rst_out", 64'({z_flags, z_out}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ack", 64'(in_ack), 64'd1);
    @(negedge clk);

    for (int i = 0; i < ND; i++) run_op($sformatf("dir%0d", i), da[i], db[i], ds[i], de[i]);

    sent = 0;
    got = 0;
    cyc = 0;
    acc = 1'b0;
    stall = 1'b0;
    held = '0;
    while (got < 16 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (stall) chk("bp_hold", 64'({z_stb, z_flags, z_out}), 64'(held));
      if (acc) in_stb = 1'b0;
      if (!in_stb && sent < 16 && $urandom_range(3) != 0) begin
        a_in = rnd_fp();
        b_in = ($urandom_range(3) == 0) ? {1'($urandom_range(1)), a_in[30:0]} : rnd_fp();
        op_sub = 1'($urandom_range(1));
        in_stb = 1'b1;
      end
      z_ack = 1'($urandom_range(1));
      #1;
      if (z_stb && z_ack) begin
        want = (expq.size() != 0) ? expq.pop_front() : '1;
        chk("bp_out", 64'({z_flags, z_out}), 64'(want));
        got++;
      end
      acc = in_stb && in_ack;
      if (acc) begin
        expq.push_back(ref_add(a_in, b_in, op_sub));
        sent++;
      end
      stall = z_stb && !z_ack;
      held = {z_stb, z_flags, z_out};
    end
    chk("bp_count", 64'(got), 64'(sent));
    chk("bp_total", 64'(got), 64'd16);

    @(negedge clk);
    in_stb = 1'b0;
    z_ack = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      a_in = rnd_fp();
      b_in = rnd_fp();
      op_sub = 1'b0;
      in_stb = 1'b1;
      @(negedge clk);
    end
    in_stb = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_stb", 64'(z_stb), 64'd0);
    chk("mid_rst_out", 64'({z_flags, z_out}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op("post_rst", 32'h3F800000, 32'h40000000, 1'b0, 36'h0_40400000);
    @(negedge clk);
    #1;
    chk("post_rst_drain", 64'(z_stb), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
